// File: rtl/tdec_pkg.sv
// -----------------------------------------------------------------------------
// tdec_pkg
// Shared constants and helpers for the toggle-stream decoder.
//
// Configuration macro: TDEC_PARITY_EN
//   undefined : 8-sample frames, all samples are data.
//   defined   : 9-sample frames, 9th recovered bit is even parity over the
//               8 data bits and is not stored in the byte.
// -----------------------------------------------------------------------------
package tdec_pkg;

  localparam int DATA_BITS = 8;

`ifdef TDEC_PARITY_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  localparam logic [7:0] UIO_OE_VAL = 8'h0F;

  // ui_in pin assignments
  localparam int Q_IDX   = 0;
  localparam int STB_IDX = 1;
  localparam int ACK_IDX = 2;
  localparam int CLR_IDX = 3;
  localparam int N_SYNC  = 4;

  // Insert one recovered bit into the assembly register. With lsb_first the
  // register shifts right so the first bit ends up in bit 0 after 8 inserts;
  // otherwise it shifts left so the first bit ends up in bit 7.
  function automatic logic [7:0] shift_in(input logic [7:0] sr,
                                          input logic       bit_in,
                                          input logic       lsb_first);
    if (lsb_first) begin
      return {bit_in, sr[7:1]};
    end
    return {sr[6:0], bit_in};
  endfunction

endpackage

// File: rtl/tdec_sync.sv
// -----------------------------------------------------------------------------
// tdec_sync
// Multi-flop input synchronizer with a rising-edge pulse.
//
// Parameters:
//   STAGES : synchronizer depth, legal range 2..3.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input pin
//   level  out synchronized level (STAGES clocks after the pin)
//   rise   out one-cycle pulse on a 0->1 transition of level
// -----------------------------------------------------------------------------
module tdec_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              level_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg    <= '0;
      level_d_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[STAGES-2:0], d};
      level_d_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  // Combinational pulse: consumed on the clock after the level first rises,
  // i.e. STAGES+1 clocks after the pin edge.
  assign rise  = sync_reg[STAGES-1] & ~level_d_reg;

endmodule

// File: rtl/tt_um_nasser_hadi_tdec.sv
// -----------------------------------------------------------------------------
// tt_um_nasser_hadi_tdec
// Toggle-stream decoder: receive end of a T flip-flop link. Samples the Q line
// on a strobe, recovers T = Q xor Q_prev, packs recovered bits into a byte and
// presents it with a valid/ack handshake.
//
// Configuration macro: TDEC_PARITY_EN (9-sample frames with even parity check).
//
// Parameters:
//   SYNC_STAGES : flops per input synchronizer (2..3)
//   LSB_FIRST   : 1 = first recovered bit -> byte bit 0, 0 = -> byte bit 7
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (released synchronously inside)
//   ena      in  design selected; when low all state is held
//   ui_in    in  [0] q_in, [1] strobe, [2] ack, [3] clear, [7:4] unused
//   uo_out   out last completed byte
//   uio_in   in  unused
//   uio_out  out [0] byte_valid, [1] overflow, [2] t_last, [3] parity_err
//   uio_oe   out constant 8'h0F
// -----------------------------------------------------------------------------
module tt_um_nasser_hadi_tdec
  import tdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on a clock edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_pipe_reg;
  logic       rst_core_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_reg <= 2'b00;
    end else begin
      rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
    end
  end

  assign rst_core_n = rst_pipe_reg[1];

  // ---------------------------------------------------------------------------
  // Input synchronizers for ui_in[3:0]
  // ---------------------------------------------------------------------------
  logic [N_SYNC-1:0] sync_level;
  logic [N_SYNC-1:0] sync_rise;

  genvar gi;
  generate
    for (gi = 0; gi < N_SYNC; gi++) begin : g_sync
      tdec_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk   (clk),
        .rst_n (rst_core_n),
        .d     (ui_in[gi]),
        .level (sync_level[gi]),
        .rise  (sync_rise[gi])
      );
    end
  endgenerate

  logic q_s;
  logic stb_p;
  logic ack_p;
  logic clr_p;

  assign q_s   = sync_level[Q_IDX];
  assign stb_p = sync_rise[STB_IDX];
  assign ack_p = sync_rise[ACK_IDX];
  assign clr_p = sync_rise[CLR_IDX];

  // ---------------------------------------------------------------------------
  // Decoder state
  // ---------------------------------------------------------------------------
  logic [7:0] shift_reg,      shift_next;
  logic [3:0] bit_cnt_reg,    bit_cnt_next;
  logic       q_ref_reg,      q_ref_next;
  logic       t_last_reg,     t_last_next;
  logic       byte_valid_reg, byte_valid_next;
  logic       overflow_reg,   overflow_next;
  logic [7:0] byte_out_reg,   byte_out_next;
  logic       parity_err_reg, parity_err_next;

  logic       t_bit;
  logic [7:0] shift_ins;
  logic [7:0] frame_byte;
  logic       frame_parity_err;
  logic       frame_done;

  assign t_bit      = q_s ^ q_ref_reg;
  assign shift_ins  = shift_in(shift_reg, t_bit, LSB_FIRST != 0);
  assign frame_done = stb_p && (bit_cnt_reg == 4'(FRAME_BITS - 1));

`ifdef TDEC_PARITY_EN
  // The completing sample is the parity bit: the byte is already assembled,
  // and even parity holds when the parity bit equals the XOR of the data.
  assign frame_byte       = shift_reg;
  assign frame_parity_err = t_bit ^ (^shift_reg);
`else
  // The completing sample is the last data bit.
  assign frame_byte       = shift_ins;
  assign frame_parity_err = 1'b0;
`endif

  always_comb begin
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    q_ref_next      = q_ref_reg;
    t_last_next     = t_last_reg;
    byte_valid_next = byte_valid_reg;
    overflow_next   = overflow_reg;
    byte_out_next   = byte_out_reg;
    parity_err_next = parity_err_reg;

    if (ena) begin
      if (clr_p) begin
        // Clear overrides a coincident strobe or ack; q_ref tracks the
        // current line level so the next sample decodes relative to it.
        shift_next      = '0;
        bit_cnt_next    = '0;
        byte_valid_next = 1'b0;
        overflow_next   = 1'b0;
        t_last_next     = 1'b0;
        parity_err_next = 1'b0;
        q_ref_next      = q_s;
      end else begin
        if (stb_p) begin
          q_ref_next   = q_s;
          t_last_next  = t_bit;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg < 4'(DATA_BITS)) begin
            shift_next = shift_ins;
          end
        end

        if (frame_done) begin
          bit_cnt_next = '0;
          shift_next   = '0;
          // A coincident ack frees the output register for the new byte.
          if (!byte_valid_reg || ack_p) begin
            byte_out_next   = frame_byte;
            byte_valid_next = 1'b1;
            parity_err_next = frame_parity_err;
          end else begin
            overflow_next = 1'b1;
          end
        end else if (ack_p) begin
          byte_valid_next = 1'b0;
          parity_err_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      q_ref_reg      <= 1'b0;
      t_last_reg     <= 1'b0;
      byte_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      byte_out_reg   <= '0;
      parity_err_reg <= 1'b0;
    end else begin
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      q_ref_reg      <= q_ref_next;
      t_last_reg     <= t_last_next;
      byte_valid_reg <= byte_valid_next;
      overflow_reg   <= overflow_next;
      byte_out_reg   <= byte_out_next;
      parity_err_reg <= parity_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign uo_out  = byte_out_reg;
  assign uio_out = {4'b0000, parity_err_reg, t_last_reg, overflow_reg, byte_valid_reg};
  assign uio_oe  = UIO_OE_VAL;

  // Inputs and sync outputs with no function in this design.
  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[7:4], sync_rise[Q_IDX],
                       sync_level[CLR_IDX:STB_IDX], 1'b0};

endmodule

// File: tb/tb_tt_um_nasser_hadi_tdec.sv
// -----------------------------------------------------------------------------
// tb_tt_um_nasser_hadi_tdec
// Self-checking bench for the toggle-stream decoder. A behavioural model is
// updated as each strobe/ack/clear is driven; the expected pin state is queued
// and compared once the event has propagated through the synchronizers.
// -----------------------------------------------------------------------------
module tb_tt_um_nasser_hadi_tdec;
  import tdec_pkg::*;

  localparam int SYNC = 2;
  localparam int LSB  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_nasser_hadi_tdec #(
    .SYNC_STAGES (SYNC),
    .LSB_FIRST   (LSB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    string      tag;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic       m_qref;
  logic [7:0] m_shift;
  int         m_cnt;
  logic       m_valid;
  logic       m_ovf;
  logic       m_tlast;
  logic       m_perr;
  logic [7:0] m_uo;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_qref  = 1'b0;
    m_shift = '0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_tlast = 1'b0;
    m_perr  = 1'b0;
    m_uo    = '0;
  endtask

  task automatic model_apply(input logic q, input logic stb, input logic ack, input logic clr);
    logic t;
    int   idx;
    if (!ena) return;
    if (clr) begin
      m_shift = '0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_tlast = 1'b0;
      m_perr  = 1'b0;
      m_qref  = q;
      return;
    end
    if (stb) begin
      t       = q ^ m_qref;
      m_qref  = q;
      m_tlast = t;
      if (m_cnt < DATA_BITS) begin
        idx = (LSB != 0) ? m_cnt : (7 - m_cnt);
        m_shift[idx] = t;
      end
      m_cnt++;
      if (m_cnt == FRAME_BITS) begin
        m_cnt = 0;
        if (!m_valid || ack) begin
          m_uo    = m_shift;
          m_valid = 1'b1;
`ifdef TDEC_PARITY_EN
          m_perr  = t ^ (^m_shift);
`endif
        end else begin
          m_ovf = 1'b1;
        end
        m_shift = '0;
        return;
      end
    end
    if (ack) begin
      m_valid = 1'b0;
      m_perr  = 1'b0;
    end
  endtask

  // Drive one event: q settles first, control pins pulse high long enough to be
  // synchronized, then low again before the result is compared.
  task automatic apply_event(input string tag, input logic q, input logic stb,
                             input logic ack, input logic clr);
    exp_t e;
    @(negedge clk);
    ui_in[Q_IDX] = q;
    @(negedge clk);
    ui_in[STB_IDX] = stb;
    ui_in[ACK_IDX] = ack;
    ui_in[CLR_IDX] = clr;
    model_apply(q, stb, ack, clr);
    e.tag = tag;
    e.uo  = m_uo;
    e.uio = {4'b0000, m_perr, m_tlast, m_ovf, m_valid};
    sb.push_back(e);
    repeat (SYNC + 2) @(negedge clk);
    ui_in[CLR_IDX:STB_IDX] = 3'b000;
    repeat (SYNC + 2) @(negedge clk);
    e = sb.pop_front();
    $display("txn %-10s q=%0b s=%0b a=%0b c=%0b ena=%0b -> uo=%02h uio=%02h", tag, q, stb, ack, clr,
             ena, uo_out, uio_out);
    check_val({e.tag, "_uo"}, uo_out, e.uo);
    check_val({e.tag, "_uio"}, uio_out, e.uio);
  endtask

  // qs[i] is the q level presented at the i-th strobe of the frame.
  task automatic send_frame(input string tag, input logic [8:0] qs, input logic ack_last);
    for (int i = 0; i < FRAME_BITS; i++) begin
      apply_event(tag, qs[i], 1'b1, ack_last && (i == FRAME_BITS - 1), 1'b0);
    end
  endtask

  initial begin
    logic [8:0] rq;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = '0;
    uio_in = '0;
    model_reset();

    // Reset state
    #23;
    check_val("rst_uo", uo_out, 8'h00);
    check_val("rst_uio", uio_out, 8'h00);
    check_val("rst_oe", uio_oe, 8'h0F);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Decode: q = 1,1,0,0,0,1,1,0 (+ parity q=0) -> 8'hA5
    send_frame("decode", 9'h063, 1'b0);
    check_val("dec_A5", uo_out, 8'hA5);
`ifdef TDEC_PARITY_EN
    check_val("dec_flags", {5'b0, uio_out[2:0]}, 8'h01);
    check_val("par_ok", {7'b0, uio_out[3]}, 8'h00);
`else
    check_val("dec_flags", {5'b0, uio_out[2:0]}, 8'h05);
`endif

    // Handshake
    apply_event("ack", 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("ack_hold", uo_out, 8'hA5);
    send_frame("zeros", 9'h000, 1'b0);
    check_val("zero_byte", uo_out, 8'h00);
    apply_event("ack_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    apply_event("ack_nop", 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: second frame dropped
    apply_event("clear", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("ovf_a", 9'h063, 1'b0);
    send_frame("ovf_b", 9'h000, 1'b0);
    check_val("ovf_keep", uo_out, 8'hA5);
    check_val("ovf_flag", {7'b0, uio_out[1]}, 8'h01);

    // Ack coincident with the completing strobe: ack wins
    apply_event("clear2", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("ackw_a", 9'h063, 1'b0);
    send_frame("ackw_b", 9'h0FF, 1'b1);
    check_val("ackw_byte", uo_out, 8'h01);
    check_val("ackw_flags", {6'b0, uio_out[1:0]}, 8'h01);
    apply_event("ack2", 1'b1, 1'b0, 1'b1, 1'b0);

    // Clear mid-frame, then a fresh frame
    for (int i = 0; i < 5; i++) begin
      apply_event("partial", 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end
    apply_event("clr_mid", 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame("post_clr", 9'h136, 1'b0);

    // Strobes while ena=0 are discarded
    apply_event("ack3", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_event("part_b", 1'(i), 1'b1, 1'b0, 1'b0);
    end
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_event("ena_off", 1'(i + 1), 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    ena = 1'b1;
    for (int i = 3; i < FRAME_BITS; i++) begin
      apply_event("ena_on", 1'(i), 1'b1, 1'b0, 1'b0);
    end

`ifdef TDEC_PARITY_EN
    // Parity bit 1 on data A5 -> parity_err
    apply_event("clear3", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame("par_bad", 9'h163, 1'b0);
    check_val("par_err", {7'b0, uio_out[3]}, 8'h01);
    apply_event("par_ack", 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    // Random frames, each acknowledged
    for (int n = 0; n < 4; n++) begin
      rq = 9'($urandom);
      send_frame("rand", rq, 1'b0);
      apply_event("rand_ack", rq[FRAME_BITS-1], 1'b0, 1'b1, 1'b0);
    end

    // Reset mid-clock: outputs clear immediately
    send_frame("pre_rst", 9'h063, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("rst2_uo", uo_out, 8'h00);
    check_val("rst2_uio", uio_out, 8'h00);
    check_val("rst2_oe", uio_oe, 8'h0F);
    @(negedge clk);
    ui_in = '0;
    rst_n = 1'b1;
    model_reset();
    repeat (8) @(negedge clk);
    send_frame("after_rst", 9'h0A3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_um_nasser_hadi_tdec.md
Name: tt_um_nasser_hadi_tdec

Overview:
- Toggle-stream decoder: the receive end of a T flip-flop link.
- Samples an external Q line (e.g. the output of the team's TFF tile) on a strobe and recovers T = Q xor Q_prev.
- Packs 8 recovered bits into a byte and presents it on uo_out with a valid/ack handshake.
- Standard Tiny Tapeout user-project top; pins only.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (legal range 2-3).
- LSB_FIRST, 1, 1 = first recovered bit lands in byte bit 0; 0 = first bit lands in bit 7.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design selected; when low, strobes are ignored and all state is held.
- ui_in  in  8  [0] q_in toggle-encoded line; [1] strobe; [2] ack; [3] clear; [7:4] unused.
- uo_out  out  8  last completed byte.
- uio_in  in  8  unused.
- uio_out  out  8  [0] byte_valid; [1] overflow (sticky); [2] t_last, the last recovered bit; [3] parity_err (see optional feature, else 0); [7:4] 0.
- uio_oe  out  8  constant 8'h0F.

Behaviour:
- Reset (async assert, sync release):
  - uo_out=0, uio_out=0.
  - shift register=0, bit_cnt=0, q_ref=0 (matches TFF reset Q=0).
- Synchronization:
  - ui_in[3:0] each pass a SYNC_STAGES synchronizer.
  - strobe, ack and clear are rising-edge detected after sync; each gives a one-cycle pulse.
- Latency: a pin edge on strobe is absorbed SYNC_STAGES+1 clocks later.
- Sample event (strobe pulse and ena=1):
  - t = q_s xor q_ref; then q_ref <= q_s; t_last <= t.
  - t shifts into the assembly register per LSB_FIRST; bit_cnt increments.
- Frame complete (bit_cnt reaches 8 on a sample): bit_cnt <= 0. Then:
  - byte_valid=0: uo_out <= assembled byte; byte_valid <= 1 on the next clock.
  - byte_valid=1 and no ack this cycle: byte dropped; overflow <= 1; uo_out held.
  - byte_valid=1 with ack in the same cycle: ack wins. New byte loads, byte_valid stays 1, no overflow.
- Ack pulse with no completion that cycle: byte_valid <= 0; uo_out holds its value.
- Ack while byte_valid=0: no effect.
- Clear pulse:
  - shift register, bit_cnt, byte_valid, overflow, t_last and parity_err go to 0.
  - q_ref <= q_s (resynchronizes to the current line level).
  - Clear overrides a coincident strobe or ack.
- Strobe pulses while ena=0 are discarded, not queued.
- Reset mid-frame discards the partial byte.
- bit_cnt width 4, wraps only through the frame-complete rule.

Optional Feature:
- Macro TDEC_PARITY_EN.
- Defined:
  - A frame is 9 samples; the 9th recovered bit is even parity over the 8 data bits and is not stored in the byte.
  - parity_err (uio_out[3]) loads with the byte and is valid while byte_valid=1.
  - parity_err clears on ack or clear.
  - A dropped frame sets overflow only.
- Undefined: 8-sample frames; uio_out[3] tied 0.

Decomposition:
- Package tdec_pkg:
  - constants DATA_BITS=8, FRAME_BITS (8 or 9 per macro), UIO_OE_VAL=8'h0F.
  - pin index constants Q_IDX=0, STB_IDX=1, ACK_IDX=2, CLR_IDX=3.
- Sub-module tdec_sync:
  - parameterized synchronizer plus rising-edge pulse.
  - instantiated for strobe, ack and clear; level-only output used for q_in.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> uo_out=0, uio_out=0 immediately, uio_oe=8'h0F.
- Decode: from reset, q sequence 1,1,0,0,0,1,1,0 with one strobe each (LSB_FIRST=1) -> uo_out=8'hA5, byte_valid=1, t_last=1.
- Handshake: pulse ack -> byte_valid=0, uo_out stays 8'hA5. Second frame with all q=0 -> uo_out=8'h00.
- Overflow: two full frames with no ack -> uo_out keeps the first byte, overflow=1. Ack coincident with the 2nd frame's 8th strobe -> second byte loaded, overflow=0.
- Clear/ena: clear after 5 strobes, then 8 strobes -> byte built only from the post-clear strobes. Strobes with ena=0 -> bit_cnt unchanged.
- Parity (TDEC_PARITY_EN): data 8'hA5 plus parity bit 0 -> parity_err=0. Parity bit 1 -> parity_err=1.
